// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared mask constants and request entry type for the frame write packer
package decoder_pkg;

  localparam logic [7:0] MASK_LO   = 8'h0F;
  localparam logic [7:0] MASK_HI   = 8'hF0;
  localparam logic [7:0] MASK_FULL = 8'hFF;

  // Entry address is sized for the widest supported ADDR_W; the top truncates on output.
  localparam int ENTRY_ADDR_W = 64;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [7:0]              wmask;
    logic [63:0]             data;
  } req_entry_t;

  function automatic logic [7:0] half_mask(input logic hi);
    return hi ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/decoder_req_fifo.sv
// rtl/decoder_req_fifo.sv - first-word-fall-through request queue, drops pushes when full
module decoder_req_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  T                         i_data,
  input  logic                     i_pop,
  output logic                     o_valid,
  output T                         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = i_pop && !w_empty;
  // A pop frees the head slot in the same edge, so a full queue can still accept.
  assign w_wr       = i_push && (!w_full || w_pop);
  assign o_overflow = i_push && w_full && !w_pop;
  assign o_valid    = !w_empty;
  assign o_count    = r_count;

  always_comb begin
    o_data = '0;
    if (!w_empty) o_data = r_mem[r_rptr];
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_rst) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/decoder_frame_wr_packer.sv
// rtl/decoder_frame_wr_packer.sv - packs 32-bit frame RAM writes into masked 64-bit memory write requests
module decoder_frame_wr_packer
  import decoder_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              flush_i,
  input  logic              fr_cs_n_i,
  input  logic              fr_wr_i,
  input  logic [13:0]       fr_addr_i,
  input  logic [31:0]       fr_data_i,
  output logic              stall_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [7:0]        mem_req_wmask_o,
  output logic [63:0]       mem_req_data_o,
  output logic              mem_req_cmd_o,
  input  logic              mem_rsp_valid_i,
  input  logic              mem_rsp_err_i,
  output logic              idle_o,
  output logic              err_o
);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  localparam int OW = $clog2(FIFO_DEPTH * 2) + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                    r_pend_valid;
  logic [12:0]             r_pend_idx;
  logic [7:0]              r_pend_mask;
  logic [63:0]             r_pend_data;
  logic [ENTRY_ADDR_W-1:0] r_pend_addr;
  logic [TW-1:0]           r_timer;
  logic [OW-1:0]           r_outst;
  logic                    r_err;

  logic                    w_wr;
  logic                    w_hi;
  logic                    w_hit;
  logic                    w_full_merge;
  logic                    w_push;
  logic                    w_overflow;
  logic                    w_accept;
  logic                    w_unused_addr;
  logic [12:0]             w_idx;
  logic [7:0]              w_new_mask;
  logic [7:0]              w_merge_mask;
  logic [63:0]             w_new_data;
  logic [63:0]             w_merge_data;
  logic [ENTRY_ADDR_W-1:0] w_new_addr;
  logic [CW-1:0]           w_fifo_count;
  req_entry_t              w_push_entry;
  req_entry_t              w_head;

  assign w_wr         = !fr_cs_n_i && fr_wr_i;
  assign w_idx        = fr_addr_i[13:1];
  assign w_hi         = fr_addr_i[0];
  assign w_new_mask   = half_mask(w_hi);
  assign w_new_data   = w_hi ? {fr_data_i, 32'h0} : {32'h0, fr_data_i};
  assign w_new_addr   = ENTRY_ADDR_W'(base_addr_i) + ENTRY_ADDR_W'({w_idx, 3'b000});
  assign w_hit        = r_pend_valid && (w_idx == r_pend_idx);
  assign w_merge_mask = r_pend_mask | w_new_mask;
  assign w_merge_data = w_hi ? {fr_data_i, r_pend_data[31:0]} : {r_pend_data[63:32], fr_data_i};
  assign w_full_merge = w_hit && (w_merge_mask == MASK_FULL);

  // One push source per cycle: a write decides first, then flush, then timeout.
  always_comb begin
    w_push             = 1'b0;
    w_push_entry.addr  = r_pend_addr;
    w_push_entry.wmask = r_pend_mask;
    w_push_entry.data  = r_pend_data;
    if (w_wr) begin
      if (w_full_merge) begin
        w_push             = 1'b1;
        w_push_entry.wmask = MASK_FULL;
        w_push_entry.data  = w_merge_data;
      end else if (r_pend_valid && !w_hit) begin
        w_push = 1'b1;
      end
    end else if (r_pend_valid && (flush_i || (r_timer == TW'(FLUSH_TIMEOUT - 1)))) begin
      w_push = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend_valid <= 1'b0;
      r_pend_idx   <= '0;
      r_pend_mask  <= '0;
      r_pend_data  <= '0;
      r_pend_addr  <= '0;
      r_timer      <= '0;
    end else if (w_wr) begin
      r_timer <= '0;
      if (w_full_merge) begin
        r_pend_valid <= 1'b0;
      end else if (w_hit) begin
        r_pend_mask <= w_merge_mask;
        r_pend_data <= w_merge_data;
      end else begin
        r_pend_valid <= 1'b1;
        r_pend_idx   <= w_idx;
        r_pend_mask  <= w_new_mask;
        r_pend_data  <= w_new_data;
        r_pend_addr  <= w_new_addr;
      end
    end else if (r_pend_valid) begin
      if (w_push) begin
        r_pend_valid <= 1'b0;
        r_timer      <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  decoder_req_fifo #(
    .T     (req_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_push     (w_push),
    .i_data     (w_push_entry),
    .i_pop      (mem_req_ready_i),
    .o_valid    (mem_req_valid_o),
    .o_data     (w_head),
    .o_count    (w_fifo_count),
    .o_overflow (w_overflow)
  );

  assign w_accept = mem_req_valid_o && mem_req_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_outst <= '0;
      r_err   <= 1'b0;
    end else begin
      case ({w_accept, mem_rsp_valid_i})
        2'b10:   if (r_outst != '1) r_outst <= r_outst + 1'b1;
        2'b01:   if (r_outst != '0) r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if (w_overflow || (mem_rsp_valid_i && mem_rsp_err_i)) r_err <= 1'b1;
    end
  end

  assign mem_req_addr_o  = w_head.addr[ADDR_W-1:0];
  assign w_unused_addr   = ^w_head.addr;
  assign mem_req_wmask_o = w_head.wmask;
  assign mem_req_data_o  = w_head.data;
  assign mem_req_cmd_o   = 1'b1;
  assign stall_o         = (w_fifo_count >= CW'(FIFO_DEPTH - 1));
  assign idle_o          = !r_pend_valid && !mem_req_valid_o && (r_outst == '0);
  assign err_o           = r_err;

endmodule

// File: tb/tb_decoder_frame_wr_packer.sv
// tb/tb_decoder_frame_wr_packer.sv - scoreboard bench for decoder_frame_wr_packer
module tb_decoder_frame_wr_packer;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] base_addr_i;
  logic        flush_i;
  logic        fr_cs_n_i;
  logic        fr_wr_i;
  logic [13:0] fr_addr_i;
  logic [31:0] fr_data_i;
  logic        stall_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic [7:0]  mem_req_wmask_o;
  logic [63:0] mem_req_data_o;
  logic        mem_req_cmd_o;
  logic        mem_rsp_valid_i;
  logic        mem_rsp_err_i;
  logic        idle_o;
  logic        err_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   rd_idx = 0;
  int   owed = 0;
  int   rsp_err_req = 0;
  int   rsp_err_used = 0;
  logic ready_fixed;
  logic rand_ready;
  logic rsp_en;

  decoder_frame_wr_packer #(
    .ADDR_W        (32),
    .FIFO_DEPTH    (4),
    .FLUSH_TIMEOUT (8)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .base_addr_i     (base_addr_i),
    .flush_i         (flush_i),
    .fr_cs_n_i       (fr_cs_n_i),
    .fr_wr_i         (fr_wr_i),
    .fr_addr_i       (fr_addr_i),
    .fr_data_i       (fr_data_i),
    .stall_o         (stall_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_wmask_o (mem_req_wmask_o),
    .mem_req_data_o  (mem_req_data_o),
    .mem_req_cmd_o   (mem_req_cmd_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .idle_o          (idle_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] bmask(input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input logic [13:0] a);
    return base + ({18'h0, a} >> 1) * 32'd8;
  endfunction

  task automatic expect_req(input logic [31:0] addr, input logic [7:0] mask, input logic [63:0] data);
    exp_t e;
    e.addr = addr;
    e.mask = mask;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Drives ready, answers accepted requests and pops the scoreboard at each falling edge.
  task automatic run_monitor();
    exp_t        e;
    logic        held;
    logic [31:0] h_addr;
    logic [7:0]  h_mask;
    logic [63:0] h_data;
    held = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_i && held && mem_req_valid_o) begin
        checks++;
        if ({mem_req_addr_o, mem_req_wmask_o, mem_req_data_o} !== {h_addr, h_mask, h_data}) begin
          errors++;
          $display("FAIL hold_stable got %h/%h/%h exp %h/%h/%h", mem_req_addr_o, mem_req_wmask_o,
                   mem_req_data_o, h_addr, h_mask, h_data);
        end
      end
      mem_req_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
      if (rst_i) begin
        held            = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_err_i   = 1'b0;
      end else begin
        held   = mem_req_valid_o && !mem_req_ready_i;
        h_addr = mem_req_addr_o;
        h_mask = mem_req_wmask_o;
        h_data = mem_req_data_o;
        if (rsp_en && owed > 0) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_err_i   = (rsp_err_used < rsp_err_req);
          if (mem_rsp_err_i) rsp_err_used++;
          owed--;
        end else begin
          mem_rsp_valid_i = 1'b0;
          mem_rsp_err_i   = 1'b0;
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
          owed++;
          checks++;
          if (rd_idx >= sb_q.size()) begin
            errors++;
            $display("FAIL unexpected_req got addr %h mask %h exp none", mem_req_addr_o, mem_req_wmask_o);
          end else begin
            e = sb_q[rd_idx];
            rd_idx++;
            if (mem_req_addr_o !== e.addr || mem_req_wmask_o !== e.mask || mem_req_cmd_o !== 1'b1 ||
                (mem_req_data_o & bmask(e.mask)) !== (e.data & bmask(e.mask))) begin
              errors++;
              $display("FAIL req_content got %h/%h/%h exp %h/%h/%h", mem_req_addr_o, mem_req_wmask_o,
                       mem_req_data_o, e.addr, e.mask, e.data);
            end
          end
        end
      end
    end
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] d);
    fr_cs_n_i = 1'b0;
    fr_wr_i   = 1'b1;
    fr_addr_i = a;
    fr_data_i = d;
    @(posedge clk_i); #1;
    fr_cs_n_i = 1'b1;
    fr_wr_i   = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n = 0;
    while (!(idle_o === 1'b1 && rd_idx == sb_q.size()) && n < max_cycles) begin
      @(posedge clk_i); #1;
      n++;
    end
    checks++;
    if (!(idle_o === 1'b1 && rd_idx == sb_q.size())) begin
      errors++;
      $display("FAIL %s_drain got idle %b consumed %0d exp idle 1 consumed %0d", name, idle_o, rd_idx, sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({idle_o, mem_req_valid_o, stall_o, err_o, mem_req_cmd_o} !== 5'b10001) begin
      errors++;
      $display("FAIL reset_flags got idle/valid/stall/err/cmd %b exp 10001",
               {idle_o, mem_req_valid_o, stall_o, err_o, mem_req_cmd_o});
    end
    checks++;
    if ({mem_req_addr_o, mem_req_wmask_o, mem_req_data_o} !== '0) begin
      errors++;
      $display("FAIL reset_req_fields got %h/%h/%h exp 0", mem_req_addr_o, mem_req_wmask_o, mem_req_data_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (idle_o !== 1'b1 || mem_req_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got idle %b valid %b exp 1 0", idle_o, mem_req_valid_o);
    end
  endtask

  task automatic test_merge();
    base_addr_i = 32'h8000_0000;
    expect_req(32'h8000_0040, 8'hFF, 64'h22222222_11111111);
    do_write(14'h0010, 32'h11111111);
    checks++;
    if (mem_req_valid_o !== 1'b0 || idle_o !== 1'b0) begin
      errors++;
      $display("FAIL merge_first_pending got valid %b idle %b exp 0 0", mem_req_valid_o, idle_o);
    end
    do_write(14'h0011, 32'h22222222);
    checks++;
    if (mem_req_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL merge_full_push got valid %b exp 1", mem_req_valid_o);
    end
    wait_drain("merge", 30);
  endtask

  task automatic test_timeout();
    base_addr_i = 32'h8000_0000;
    expect_req(32'h8000_0008, 8'hF0, 64'hABCD0123_00000000);
    do_write(14'h0003, 32'hABCD0123);
    fr_cs_n_i = 1'b0;
    fr_wr_i   = 1'b0;
    fr_addr_i = 14'h0200;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (mem_req_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL timeout_early idle_cycle %0d got valid %b exp 0", i + 1, mem_req_valid_o);
      end
    end
    @(posedge clk_i); #1;
    fr_cs_n_i = 1'b1;
    checks++;
    if (mem_req_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_emit got valid %b exp 1", mem_req_valid_o);
    end
    wait_drain("timeout", 20);
  endtask

  task automatic test_flush();
    base_addr_i = 32'h8000_0000;
    expect_req(32'h8000_0010, 8'h0F, 64'h00000000_44444444);
    expect_req(32'h8000_0020, 8'h0F, 64'h00000000_88888888);
    do_write(14'h0004, 32'h44444444);
    do_write(14'h0008, 32'h88888888);
    checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h8000_0010 || idle_o !== 1'b0) begin
      errors++;
      $display("FAIL evict_push got valid %b addr %h idle %b exp 1 80000010 0",
               mem_req_valid_o, mem_req_addr_o, idle_o);
    end
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h8000_0020) begin
      errors++;
      $display("FAIL flush_push got valid %b addr %h exp 1 80000020", mem_req_valid_o, mem_req_addr_o);
    end
    wait_drain("flush", 20);
  endtask

  task automatic test_overflow();
    logic [13:0] a;
    base_addr_i = 32'h1000_0000;
    ready_fixed = 1'b0;
    @(posedge clk_i); #1;
    for (int k = 0; k < 6; k++) begin
      a = 14'h0100 + 14'(2 * k);
      if (k != 4) expect_req(exp_addr(base_addr_i, a), 8'h0F, {32'h0, 32'hD000_0000 + 32'(k)});
      do_write(a, 32'hD000_0000 + 32'(k));
      checks++;
      if (stall_o !== ((k < 4 ? k : 4) >= 3) || err_o !== (k >= 5)) begin
        errors++;
        $display("FAIL overflow_write%0d got stall %b err %b exp %b %b", k, stall_o, err_o,
                 ((k < 4 ? k : 4) >= 3), (k >= 5));
      end
    end
    ready_fixed = 1'b1;
    wait_drain("overflow", 60);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got err %b exp 1", err_o);
    end
  endtask

  task automatic test_reset_midstream();
    ready_fixed = 1'b0;
    @(posedge clk_i); #1;
    do_write(14'h0300, 32'h0000_0001);
    do_write(14'h0302, 32'h0000_0002);
    do_write(14'h0304, 32'h0000_0003);
    checks++;
    if (mem_req_valid_o !== 1'b1 || idle_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_setup got valid %b idle %b exp 1 0", mem_req_valid_o, idle_o);
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    checks++;
    if ({mem_req_valid_o, idle_o, err_o, stall_o} !== 4'b0100 ||
        {mem_req_addr_o, mem_req_wmask_o, mem_req_data_o} !== '0) begin
      errors++;
      $display("FAIL midreset_state got valid/idle/err/stall %b fields %h/%h/%h exp 0100 and 0",
               {mem_req_valid_o, idle_o, err_o, stall_o}, mem_req_addr_o, mem_req_wmask_o, mem_req_data_o);
    end
    ready_fixed = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (mem_req_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cycle %0d got valid %b exp 0", i, mem_req_valid_o);
      end
    end
  endtask

  task automatic test_rsp_err();
    int n = 0;
    base_addr_i = 32'h2000_0000;
    rsp_en      = 1'b0;
    rsp_err_req = rsp_err_req + 1;
    expect_req(32'h2000_0100, 8'hFF, 64'h0000000B_0000000A);
    do_write(14'h0040, 32'h0000000A);
    do_write(14'h0041, 32'h0000000B);
    while (rd_idx != sb_q.size() && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (rd_idx != sb_q.size() || idle_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL rsp_outstanding got consumed %0d idle %b err %b exp %0d 0 0", rd_idx, idle_o, err_o, sb_q.size());
    end
    rsp_en = 1'b1;
    wait_drain("rsp_err", 20);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL rsp_err_flag got err %b exp 1", err_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] a;
    logic [31:0] lo;
    logic [31:0] hi;
    int          n;
    base_addr_i = 32'h3000_0000;
    rand_ready  = 1'b1;
    for (int w = 0; w < 10; w++) begin
      n = 0;
      while (stall_o === 1'b1 && n < 50) begin
        @(posedge clk_i); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL b2b_stall_timeout got stall %b exp 0", stall_o);
      end
      a  = 14'h0500 + 14'(2 * w);
      lo = $urandom;
      hi = $urandom;
      expect_req(exp_addr(base_addr_i, a), 8'hFF, {hi, lo});
      do_write(a, lo);
      do_write(a | 14'h0001, hi);
    end
    rand_ready  = 1'b0;
    ready_fixed = 1'b1;
    wait_drain("b2b", 100);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_err_sticky got err %b exp 1", err_o);
    end
  endtask

  initial begin
    rst_i           = 1'b1;
    base_addr_i     = '0;
    flush_i         = 1'b0;
    fr_cs_n_i       = 1'b1;
    fr_wr_i         = 1'b0;
    fr_addr_i       = '0;
    fr_data_i       = '0;
    ready_fixed     = 1'b1;
    rand_ready      = 1'b0;
    rsp_en          = 1'b1;
    mem_req_ready_i = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_err_i   = 1'b0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_merge();
    test_timeout();
    test_flush();
    test_overflow();
    test_reset_midstream();
    test_rsp_err();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_frame_wr_packer.md
DECODER_FRAME_WR_PACKER -- requirements
Module: decoder_frame_wr_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of memory addresses.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of request FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 8, idle cycles before a half-filled pending word is emitted.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_i  in  1  synchronous reset, active-high.
REQ-007 base_addr_i  in  ADDR_W  frame buffer byte base address; sampled when a word enters pending.
REQ-008 flush_i  in  1  level request to emit the pending word.
REQ-009 fr_cs_n_i  in  1  frame RAM chip select, active-low.
REQ-010 fr_wr_i  in  1  frame RAM write strobe; a write is fr_cs_n_i=0 and fr_wr_i=1.
REQ-011 fr_addr_i  in  14  32-bit word address.
REQ-012 fr_data_i  in  32  write data.
REQ-013 stall_o  out  1  high when the FIFO holds at least FIFO_DEPTH-1 entries.
REQ-014 mem_req_valid_o / mem_req_ready_i  out/in  1  memory request handshake.
REQ-015 mem_req_addr_o  out  ADDR_W  = base + {fr_addr[13:1], 3'b000}.
REQ-016 mem_req_wmask_o  out  8; mem_req_data_o  out  64; mem_req_cmd_o  out  1, constant 1 (write).
REQ-017 mem_rsp_valid_i, mem_rsp_err_i  in  1 each  write acknowledge and its error flag.
REQ-018 idle_o  out  1  high when nothing is pending, the FIFO is empty and no response is outstanding.
REQ-019 err_o  out  1  sticky flag, set by FIFO overflow or by mem_rsp_err_i.

Function
REQ-020 SHALL hold one pending 64-bit word: valid flag, dword index fr_addr[13:1], 8-bit mask, data.
- Low half (fr_addr[0]=0): data[31:0], mask 0x0F.
- High half: data[63:32], mask 0xF0.
REQ-021 A write to the same dword as pending SHALL merge into it; same half overwrites (last wins).
- If the merged mask becomes 0xFF, the word SHALL be pushed that cycle and pending cleared.
REQ-022 A write to a different dword SHALL push the old pending word and load the new write as pending, in the same cycle.
REQ-023 A write with nothing pending SHALL load pending; no push.
REQ-024 SHALL perform at most one FIFO push per cycle; a write takes priority over flush and over timeout.
REQ-025 With flush_i high, no write and pending valid, pending SHALL be pushed that cycle.
REQ-026 Timeout counter:
- clears on every write;
- increments each cycle pending is valid with no write;
- reaching FLUSH_TIMEOUT-1 SHALL push pending.
REQ-027 FIFO SHALL be first-word-fall-through.
- mem_req_valid_o = not empty.
- Entry popped on valid&&ready.
- Push and pop in the same cycle are legal when full.
- Empty-to-valid latency is 1 cycle after push.
REQ-028 A push when full with no simultaneous pop SHALL drop the entry and set err_o.
REQ-029 Outstanding counter (width clog2(FIFO_DEPTH*2)+1):
- +1 per accepted request, -1 per mem_rsp_valid_i;
- simultaneous accept and response leaves it unchanged;
- saturates at both ends.
REQ-030 Reads (fr_cs_n_i=0, fr_wr_i=0) and deselected cycles SHALL be ignored.
REQ-031 mem_req_* outputs SHALL be held stable while valid and not ready.

Reset
REQ-032 On rst_i high at a clock edge, the following SHALL clear to 0, discarding any in-flight data:
- pending valid, FIFO pointers, timeout and outstanding counters;
- err_o, mem_req_valid_o, stall_o.
REQ-033 During and after reset: idle_o=1, mem_req_cmd_o=1, mem_req_addr_o/wmask_o/data_o=0.

Structure
REQ-034 Shared package decoder_pkg SHALL hold:
- mask constants MASK_LO=0x0F, MASK_HI=0xF0, MASK_FULL=0xFF;
- the FIFO entry struct (addr, wmask, data).
REQ-035 The FIFO SHALL be a separate sub-module decoder_req_fifo, parameterised by entry type and depth.

Verification
REQ-036 base=0x8000_0000; writes to addr 0x0010 (data 0x11111111) then 0x0011 (data 0x22222222) on consecutive cycles -> one request: addr 0x8000_0040, wmask 0xFF, data 0x22222222_11111111.
REQ-037 Single write to addr 0x0003 (data 0xABCD0123), then idle -> after 8 idle cycles, one request: addr base+0x08, wmask 0xF0, data[63:32]=0xABCD0123.
REQ-038 Writes to 0x0004 then 0x0008 -> first request addr base+0x10, wmask 0x0F, issued while 0x0008 is pending; flush_i pulse then emits base+0x20, mask 0x0F.
REQ-039 mem_req_ready_i=0, 6 non-mergeable writes -> stall_o rises after the 3rd push; the 5th push is dropped with err_o=1; other entries drain in order once ready=1.
REQ-040 Assert rst_i mid-stream with 2 entries queued and pending valid -> next cycle mem_req_valid_o=0, idle_o=1, err_o=0; no stale request after reset.
REQ-041 mem_rsp_err_i=1 on one acknowledge -> err_o=1 until reset; idle_o returns to 1 once all responses are received.
